gcm_prefetch_gate: RTL and testbench

//  Parametrised gate control module: steps through the gate control list (GCL) in RAM,
//  one word per slot cycle. Each word carries SLOTS gate vectors of CH bits.

---
 rtl/gcm_prefetch_gate_pkg.sv | 14 +
 rtl/gcm_gcl_fetch.sv | 101 ++++++++++
 rtl/gcm_prefetch_gate.sv | 66 ++++++
 tb/tb_gcm_prefetch_gate.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/gcm_prefetch_gate_pkg.sv
// gcm_prefetch_gate_pkg: GCL fetch FSM encodings and the slot-index width helper.
package gcm_prefetch_gate_pkg;
  localparam logic [2:0] S_INIT  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_LOAD  = 3'd3;
  localparam logic [2:0] S_FULL  = 3'd4;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/gcm_gcl_fetch.sv
// gcm_gcl_fetch: GCL RAM fetch FSM, address wrap, read-latency counter and active/shadow buffers.
module gcm_gcl_fetch
  import gcm_prefetch_gate_pkg::*;
#(
  parameter int CH     = 8,
  parameter int SLOTS  = 16,
  parameter int AW     = 5,
  parameter int RD_LAT = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stop_i,
  input  logic                cfg_done_i,
  input  logic [AW-1:0]       cfg_last_i,
  input  logic                wrap_i,
  input  logic [CH*SLOTS-1:0] gcl_data_i,
  output logic                gcl_rd_o,
  output logic [AW-1:0]       gcl_addr_o,
  output logic [CH*SLOTS-1:0] active_o,
  output logic                active_vld_o,
  output logic                underrun_ev_o
);
  localparam int W  = CH * SLOTS;
  localparam int LW = clog2(RD_LAT) + 1;
  logic [2:0]    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          rd_q, rd_d;
  logic [W-1:0]  active_q, active_d, shadow_q, shadow_d;
  logic          active_vld_q, active_vld_d, shadow_vld_q, shadow_vld_d;
  // a word landing in the same cycle as the wrap is still in time, so it is no underrun
  assign underrun_ev_o = wrap_i & ~shadow_vld_q & (state_q != S_LOAD) & ~stop_i;
  assign gcl_rd_o      = rd_q;
  assign gcl_addr_o    = addr_q;
  assign active_o      = active_q;
  assign active_vld_o  = active_vld_q;
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    rd_d         = 1'b0;
    active_d     = wrap_i ? shadow_q : active_q;
    active_vld_d = wrap_i ? shadow_vld_q : active_vld_q;
    shadow_d     = shadow_q;
    shadow_vld_d = wrap_i ? 1'b0 : shadow_vld_q;
    case (state_q)
      S_INIT:  state_d = cfg_done_i ? S_FETCH : S_INIT;
      S_FETCH: begin
        rd_d    = 1'b1;
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == LW'(RD_LAT - 1)) ? S_LOAD : S_WAIT;
      end
      S_LOAD: begin
        if (active_vld_d) begin
          shadow_d     = gcl_data_i;
          shadow_vld_d = 1'b1;
        end else begin
          active_d     = gcl_data_i;
          active_vld_d = 1'b1;
        end
        addr_d  = (addr_q >= cfg_last_i) ? '0 : addr_q + 1'b1;
        state_d = (active_vld_d && shadow_vld_d) ? S_FULL : S_FETCH;
      end
      S_FULL:  state_d = shadow_vld_q ? S_FULL : S_FETCH;
      default: state_d = S_INIT;
    endcase
    if (stop_i) begin
      state_d      = S_INIT;
      addr_d       = '0;
      cnt_d        = '0;
      rd_d         = 1'b0;
      active_vld_d = 1'b0;
      shadow_vld_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_INIT;
      addr_q       <= '0;
      cnt_q        <= '0;
      rd_q         <= 1'b0;
      active_q     <= '0;
      shadow_q     <= '0;
      active_vld_q <= 1'b0;
      shadow_vld_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      rd_q         <= rd_d;
      active_q     <= active_d;
      shadow_q     <= shadow_d;
      active_vld_q <= active_vld_d;
      shadow_vld_q <= shadow_vld_d;
    end
  end
endmodule

// File: rtl/gcm_prefetch_gate.sv
// gcm_prefetch_gate: steps through the GCL slot by slot and masks TGM requests with the current gate vector.
module gcm_prefetch_gate
  import gcm_prefetch_gate_pkg::*;
#(
  parameter int CH     = 8,
  parameter int SLOTS  = 16,
  parameter int AW     = 5,
  parameter int RD_LAT = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_done_i,
  input  logic [AW-1:0]              cfg_last_i,
  input  logic                       test_start_i,
  input  logic                       test_stop_i,
  input  logic                       slot_shift_i,
  input  logic [CH-1:0]              req_i,
  output logic                       gcl_rd_o,
  output logic [AW-1:0]              gcl_addr_o,
  input  logic [CH*SLOTS-1:0]        gcl_data_i,
  output logic [CH-1:0]              gate_valid_o,
  output logic [clog2(SLOTS)-1:0]    slot_idx_o,
  output logic                       underrun_o
);
  localparam int SW = clog2(SLOTS);
  logic [SW-1:0]       slot_q, slot_d;
  logic [CH-1:0]       gate_q, gate_d;
  logic                underrun_q, underrun_d;
  logic                adv, wrap, underrun_ev, active_vld;
  logic [CH*SLOTS-1:0] active;
  assign adv  = test_start_i & slot_shift_i;
  assign wrap = adv & (slot_q == SW'(SLOTS - 1));
  gcm_gcl_fetch #(.CH(CH), .SLOTS(SLOTS), .AW(AW), .RD_LAT(RD_LAT)) u_fetch (
    .clk           (clk),
    .rst_n         (rst_n),
    .stop_i        (test_stop_i),
    .cfg_done_i    (cfg_done_i),
    .cfg_last_i    (cfg_last_i),
    .wrap_i        (wrap),
    .gcl_data_i    (gcl_data_i),
    .gcl_rd_o      (gcl_rd_o),
    .gcl_addr_o    (gcl_addr_o),
    .active_o      (active),
    .active_vld_o  (active_vld),
    .underrun_ev_o (underrun_ev)
  );
  always_comb begin
    slot_d     = test_stop_i ? '0 : slot_q + SW'(adv);
    gate_d     = (!test_stop_i && active_vld && test_start_i) ? active[slot_q*CH +: CH] & req_i : '0;
    underrun_d = !test_stop_i && (underrun_q || underrun_ev);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q     <= '0;
      gate_q     <= '0;
      underrun_q <= 1'b0;
    end else begin
      slot_q     <= slot_d;
      gate_q     <= gate_d;
      underrun_q <= underrun_d;
    end
  end
  assign gate_valid_o = gate_q;
  assign slot_idx_o   = slot_q;
  assign underrun_o   = underrun_q;
endmodule

// File: tb/tb_gcm_prefetch_gate.sv
// tb_gcm_prefetch_gate: directed bench with RAM models for RD_LAT=2 and RD_LAT=6 instances.
module tb_gcm_prefetch_gate;
  import gcm_prefetch_gate_pkg::*;
  localparam int CH = 8, SLOTS = 16, AW = 5, W = CH * SLOTS;
  typedef struct {
    string       tag;
    logic [31:0] v;
  } exp_t;
  logic          clk, rst_n, cfg_done, test_start, test_stop, slot_shift;
  logic [AW-1:0] cfg_last;
  logic [CH-1:0] req;
  logic          gcl_rd, underrun, rd6, und6;
  logic [AW-1:0] gcl_addr, addr6;
  logic [W-1:0]  gcl_data, data6;
  logic [CH-1:0] gate_valid, gate6;
  logic [3:0]    slot_idx, slot6;
  logic [W-1:0]  mem [0:31];
  logic [1:0]            pv2;
  logic [1:0][AW-1:0]    pa2;
  logic [5:0]            pv6;
  logic [5:0][AW-1:0]    pa6;
  exp_t sbq[$];
  int   rdq[$];
  int   seen_q[$];
  int   rd_ptr, checks, errors, m_slot, m_word;
  bit   mon_en, found;

  gcm_prefetch_gate #(.CH(CH), .SLOTS(SLOTS), .AW(AW), .RD_LAT(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .cfg_done_i(cfg_done), .cfg_last_i(cfg_last),
    .test_start_i(test_start), .test_stop_i(test_stop), .slot_shift_i(slot_shift),
    .req_i(req), .gcl_rd_o(gcl_rd), .gcl_addr_o(gcl_addr), .gcl_data_i(gcl_data),
    .gate_valid_o(gate_valid), .slot_idx_o(slot_idx), .underrun_o(underrun)
  );
  gcm_prefetch_gate #(.CH(CH), .SLOTS(SLOTS), .AW(AW), .RD_LAT(6)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .cfg_done_i(cfg_done), .cfg_last_i(cfg_last),
    .test_start_i(test_start), .test_stop_i(test_stop), .slot_shift_i(slot_shift),
    .req_i(req), .gcl_rd_o(rd6), .gcl_addr_o(addr6), .gcl_data_i(data6),
    .gate_valid_o(gate6), .slot_idx_o(slot6), .underrun_o(und6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM models: data is only meaningful exactly RD_LAT cycles after the strobe
  always @(posedge clk) begin
    pv2 <= {pv2[0], gcl_rd};
    pa2 <= {pa2[0], gcl_addr};
    pv6 <= {pv6[4:0], rd6};
    pa6 <= {pa6[4:0], addr6};
  end
  assign gcl_data = pv2[1] ? mem[pa2[1]] : {16{8'hEE}};
  assign data6    = pv6[5] ? mem[pa6[5]] : {16{8'hEE}};

  always @(negedge clk) if (mon_en && gcl_rd) seen_q.push_back(int'(gcl_addr));

  function automatic logic [7:0] bytev(input int w, input int s);
    return (w == 0) ? 8'(1 << (s % 8)) : 8'(w * 16 + s);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sbq.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    if (sbq.size() == 0) check("sb_underflow", 32'(sbq.size()), 1);
    else begin
      e = sbq.pop_front();
      check(e.tag, obs, e.v);
    end
  endtask

  task automatic rd_check();
    check("rd_count", 32'(seen_q.size() - rd_ptr), 32'(rdq.size()));
    while (rdq.size() != 0 && rd_ptr < seen_q.size()) begin
      check("rd_addr", 32'(seen_q[rd_ptr]), 32'(rdq.pop_front()));
      rd_ptr++;
    end
    rdq.delete();
    rd_ptr = seen_q.size();
  endtask

  task automatic shift(input logic [7:0] r);
    @(negedge clk);
    slot_shift = 1'b1;
    req = r;
    m_slot = (m_slot + 1) % SLOTS;
    if (m_slot == 0) m_word = (m_word == 2) ? 0 : m_word + 1;
    push("gate", 32'(bytev(m_word, m_slot) & r));
    @(negedge clk);
    slot_shift = 1'b0;
    @(negedge clk);
    pop_check(32'(gate_valid));
    check("slot_idx", 32'(slot_idx), 32'(m_slot));
  endtask

  initial begin
    for (int w = 0; w < 32; w++)
      for (int s = 0; s < SLOTS; s++) mem[w][s*8 +: 8] = bytev(w, s);
    rst_n = 1'b0; cfg_done = 1'b0; cfg_last = 5'd2; test_start = 1'b0;
    test_stop = 1'b0; slot_shift = 1'b0; req = '0; mon_en = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rd", gcl_rd, 0);
    check("rst_addr", gcl_addr, 0);
    check("rst_gate", gate_valid, 0);
    check("rst_slot", slot_idx, 0);
    check("rst_underrun", underrun, 0);
    // 1: two prefetches fill active and shadow, then idle
    cfg_done = 1'b1; mon_en = 1'b1; rdq = '{0, 1}; rst_n = 1'b1;
    repeat (16) @(negedge clk);
    rd_check();
    check("t1_rd_idle", gcl_rd, 0);
    check("t1_addr", gcl_addr, 2);
    // 2: slot 0 then slot 1 of word 0
    test_start = 1'b1; req = 8'hFF; m_slot = 0; m_word = 0;
    push("t2_gate0", 8'h01);
    @(negedge clk);
    pop_check(32'(gate_valid));
    shift(8'hFF);
    // 3: words 0,1,2,0 in turn with address wrap
    rdq = '{2, 0, 1};
    for (int i = 0; i < 47; i++) shift(8'hFF ^ 8'(i * 29));
    repeat (8) @(negedge clk);
    rd_check();
    check("t3_addr", gcl_addr, 2);
    check("t3_underrun", underrun, 0);
    // 5: stop coincident with a slot shift in slot 7
    for (int i = 0; i < 7; i++) shift(8'hFF);
    @(negedge clk);
    test_stop = 1'b1; slot_shift = 1'b1;
    @(negedge clk);
    test_stop = 1'b0; slot_shift = 1'b0;
    check("t5_gate", gate_valid, 0);
    check("t5_slot", slot_idx, 0);
    check("t5_addr", gcl_addr, 0);
    check("t5_rd", gcl_rd, 0);
    check("t5_state", u_dut.u_fetch.state_q, S_INIT);
    m_slot = 0; m_word = 0; rdq = '{0, 1};
    push("t5_gate_restart", 8'h01);
    repeat (14) @(negedge clk);
    rd_check();
    pop_check(32'(gate_valid));
    check("t5_addr_full", gcl_addr, 2);
    // 6: async reset while waiting on the RAM
    rdq = '{2};
    repeat (16) shift(8'hFF);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      found = gcl_rd;
    end
    check("t6_rd_seen", found, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_rd", gcl_rd, 0);
    check("t6_rst_gate", gate_valid, 0);
    check("t6_rst_slot", slot_idx, 0);
    check("t6_rst_addr", gcl_addr, 0);
    rd_check();
    mon_en = 1'b0; cfg_done = 1'b0; test_start = 1'b1; req = 8'hFF; slot_shift = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t6_no_stale_gate", gate_valid, 0);
      check("t6_no_rd", gcl_rd, 0);
    end
    // 4: slot_shift every cycle; the RD_LAT=6 instance cannot keep up
    rst_n = 1'b0; slot_shift = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    cfg_done = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      found = und6;
    end
    check("t4_underrun6", found, 1);
    check("t4_gate6_last", gate6, 8'h80);
    @(negedge clk);
    check("t4_gate6_closed", gate6, 0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = (gate6 != 0);
    end
    check("t4_gate6_reopen", found, 1);
    repeat (20) @(negedge clk);
    check("t4_underrun6_sticky", und6, 1);
    check("t4_underrun2", underrun, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
